// File: rtl/sap_pkg.sv
// Shared types and helper functions for the SAP control unit and datapath.
package sap_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  typedef enum logic [3:0] {
    OPC_NOP = 4'h0,
    OPC_LDA = 4'h1,
    OPC_LDB = 4'h2,
    OPC_INA = 4'h3,
    OPC_INB = 4'h4,
    OPC_ADD = 4'h5,
    OPC_SUB = 4'h6,
    OPC_AND = 4'h7,
    OPC_OR  = 4'h8,
    OPC_JMP = 4'h9,
    OPC_JZ  = 4'hA,
    OPC_JC  = 4'hB,
    OPC_HLT = 4'hF
  } sap_opcode_e;

  typedef logic [2:0] ctrl_state_e;
  localparam ctrl_state_e ST_FETCH      = 3'd0;
  localparam ctrl_state_e ST_DECODE     = 3'd1;
  localparam ctrl_state_e ST_FETCH_OPND = 3'd2;
  localparam ctrl_state_e ST_EXEC       = 3'd3;
  localparam ctrl_state_e ST_HALT       = 3'd4;

  function automatic logic is_two_byte(input logic [3:0] opc);
    case (sap_opcode_e'(opc))
      OPC_LDA, OPC_LDB, OPC_JMP, OPC_JZ, OPC_JC: is_two_byte = 1'b1;
      default:                                   is_two_byte = 1'b0;
    endcase
  endfunction

  function automatic logic is_defined(input logic [3:0] opc);
    case (sap_opcode_e'(opc))
      OPC_NOP, OPC_LDA, OPC_LDB, OPC_INA, OPC_INB, OPC_ADD, OPC_SUB,
      OPC_AND, OPC_OR, OPC_JMP, OPC_JZ, OPC_JC, OPC_HLT: is_defined = 1'b1;
      default:                                           is_defined = 1'b0;
    endcase
  endfunction

  function automatic alu_op_e opc_to_aluop(input logic [3:0] opc);
    case (sap_opcode_e'(opc))
      OPC_SUB: opc_to_aluop = ALU_SUB;
      OPC_AND: opc_to_aluop = ALU_AND;
      OPC_OR:  opc_to_aluop = ALU_OR;
      default: opc_to_aluop = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/sap_controller_decoder.sv
// Combinational strobe decode: strobes are only ever non-zero in EXEC.
module sap_decoder
  import sap_pkg::*;
#(
  parameter int N = 8
) (
  input  ctrl_state_e      state_i,
  input  logic [3:0]       opc_i,
  input  logic [N-1:0]     opnd_i,
  input  logic             zf_i,
  input  logic             cf_i,
  output alu_op_e          op_o,
  output logic             en_a_o,
  output logic             en_b_o,
  output logic             sel_a_o,
  output logic             sel_b_o,
  output logic             load_out_o,
  output logic [N-1:0]     imm_data_o,
  output logic             jump_o
);

  // Strobe bundle and jump decision from state and opcode
  always_comb begin
    op_o       = ALU_ADD;
    en_a_o     = 1'b0;
    en_b_o     = 1'b0;
    sel_a_o    = 1'b0;
    sel_b_o    = 1'b0;
    load_out_o = 1'b0;
    imm_data_o = {N{1'b0}};
    jump_o     = 1'b0;
    if (state_i == ST_EXEC) begin
      case (sap_opcode_e'(opc_i))
        OPC_LDA: begin en_a_o = 1'b1; imm_data_o = opnd_i; end
        OPC_LDB: begin en_b_o = 1'b1; imm_data_o = opnd_i; end
        OPC_INA: begin en_a_o = 1'b1; sel_a_o = 1'b1; end
        OPC_INB: begin en_b_o = 1'b1; sel_b_o = 1'b1; end
        OPC_ADD, OPC_SUB, OPC_AND, OPC_OR: begin
          op_o       = opc_to_aluop(opc_i);
          load_out_o = 1'b1;
        end
        OPC_JMP: jump_o = 1'b1;
        OPC_JZ:  jump_o = zf_i;
        OPC_JC:  jump_o = cf_i;
        default: jump_o = 1'b0;
      endcase
    end else begin
      jump_o = 1'b0;
    end
  end

endmodule

// File: rtl/sap_controller.sv
// SAP control unit: fetch/decode/execute FSM driving the 8-bit datapath strobes.
module sap_controller
  import sap_pkg::*;
#(
  parameter int N  = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [N-1:0]  imem_rdata,
  input  logic          z,
  input  logic          n,
  input  logic          c,
  input  logic          v,
  output alu_op_e       op,
  output logic          en_A,
  output logic          en_B,
  output logic          sel_A,
  output logic          sel_B,
  output logic          load_out,
  output logic [N-1:0]  imm_data,
  output logic          halted,
  output logic          illegal,
  output logic [AW-1:0] pc
);

  ctrl_state_e   state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [N-1:0]  ir_q, ir_d;
  logic [N-1:0]  opnd_q, opnd_d;
  logic          zf_q, zf_d, cf_q, cf_d;
  logic          ill_q, ill_d;
  logic          req_q, req_d;
  logic [3:0]    opc_s;
  logic          accept_s;
  logic          jump_s;
  logic          unused_ok_s;

  assign opc_s       = ir_q[N-1:N-4];
  assign accept_s    = req_q & imem_valid;
  assign unused_ok_s = ^{n, v, ir_q[N-5:0]};

  sap_decoder #(.N(N)) u_dec (
    .state_i    (state_q),
    .opc_i      (opc_s),
    .opnd_i     (opnd_q),
    .zf_i       (zf_q),
    .cf_i       (cf_q),
    .op_o       (op),
    .en_a_o     (en_A),
    .en_b_o     (en_B),
    .sel_a_o    (sel_A),
    .sel_b_o    (sel_B),
    .load_out_o (load_out),
    .imm_data_o (imm_data),
    .jump_o     (jump_s)
  );

  // Next-state logic for the fetch/decode/execute sequence
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    zf_d    = zf_q;
    cf_d    = cf_q;
    ill_d   = ill_q;
    case (state_q)
      ST_FETCH: begin
        if (accept_s) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
          state_d = ST_DECODE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (opc_s == OPC_HLT) begin
          state_d = ST_HALT;
        end else if (is_two_byte(opc_s)) begin
          state_d = ST_FETCH_OPND;
        end else begin
          ill_d   = ill_q | ~is_defined(opc_s);
          state_d = ST_EXEC;
        end
      end
      ST_FETCH_OPND: begin
        if (accept_s) begin
          opnd_d  = imem_rdata;
          pc_d    = pc_q + {{(AW-1){1'b0}}, 1'b1};
          state_d = ST_EXEC;
        end else begin
          state_d = ST_FETCH_OPND;
        end
      end
      ST_EXEC: begin
        if (load_out) begin
          zf_d = z;
          cf_d = c;
        end else begin
          zf_d = zf_q;
        end
        if (jump_s) begin
          pc_d = opnd_q[AW-1:0];
        end else begin
          pc_d = pc_q;
        end
        state_d = ST_FETCH;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
    // Request is registered, so it is raised for the state being entered
    req_d = (state_d == ST_FETCH) || (state_d == ST_FETCH_OPND);
  end

  // State and datapath-control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= {AW{1'b0}};
      ir_q    <= {N{1'b0}};
      opnd_q  <= {N{1'b0}};
      zf_q    <= 1'b0;
      cf_q    <= 1'b0;
      ill_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
      zf_q    <= zf_d;
      cf_q    <= cf_d;
      ill_q   <= ill_d;
      req_q   <= req_d;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign illegal   = ill_q;

endmodule

// File: tb/tb_sap_controller.sv
// Directed bench for sap_controller with an imem responder and a datapath model.
module tb_sap_controller;
  import sap_pkg::*;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       imem_req, imem_valid;
  logic [7:0] imem_addr, imem_rdata;
  logic       z, n, c, v;
  alu_op_e    op;
  logic       en_A, en_B, sel_A, sel_B, load_out;
  logic [7:0] imm_data, pc;
  logic       halted, illegal;

  typedef struct {
    logic [4:0] fl;   // {en_A, en_B, sel_A, sel_B, load_out}
    alu_op_e    op;
    logic [7:0] imm;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fetch_log[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         delay   = 0;
  int         wcnt;
  logic [7:0] mem [256];

  localparam logic [7:0] BUS_IN = 8'h3C;
  logic [7:0] a_q, b_q, out_q, res_s;
  logic       cy_s;

  sap_controller #(.N(8), .AW(8)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .z(z), .n(n), .c(c), .v(v),
    .op(op), .en_A(en_A), .en_B(en_B), .sel_A(sel_A), .sel_B(sel_B),
    .load_out(load_out), .imm_data(imm_data),
    .halted(halted), .illegal(illegal), .pc(pc)
  );

  always #5 clk = ~clk;

  // Instruction memory responder with a programmable wait count
  assign imem_valid = imem_req && (wcnt >= delay);
  assign imem_rdata = mem[imem_addr];
  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if (imem_req && !imem_valid) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // Datapath model: registers A/B, ALU, output register
  always @* begin
    cy_s  = 1'b0;
    res_s = 8'h00;
    case (op)
      ALU_ADD: {cy_s, res_s} = {1'b0, a_q} + {1'b0, b_q};
      ALU_SUB: {cy_s, res_s} = {1'b0, a_q} - {1'b0, b_q};
      ALU_AND: res_s = a_q & b_q;
      ALU_OR:  res_s = a_q | b_q;
      default: res_s = 8'h00;
    endcase
  end
  assign z = (res_s == 8'h00);
  assign c = cy_s;
  assign n = res_s[7];
  assign v = (a_q[7] == b_q[7]) && (res_s[7] != a_q[7]);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q <= 8'h00; b_q <= 8'h00; out_q <= 8'h00;
    end else begin
      if (en_A) a_q <= sel_A ? BUS_IN : imm_data;
      if (en_B) b_q <= sel_B ? BUS_IN : imm_data;
      if (load_out) out_q <= res_s;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe scoreboard, fetch-address log and address-stability monitor
  initial begin
    logic       hold_chk;
    logic [7:0] prev_addr;
    ev_t        e;
    hold_chk  = 1'b0;
    prev_addr = 8'h00;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (hold_chk) chk("addr_stable", imem_addr, prev_addr);
        hold_chk  = imem_req && !imem_valid;
        prev_addr = imem_addr;
        if (imem_req && imem_valid) fetch_log.push_back(imem_addr);
        if (en_A || en_B || load_out) begin
          n_tests++;
          assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL strobe_unexpected: got %b expected none", {en_A, en_B, sel_A, sel_B, load_out});
          end
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("strobes", {en_A, en_B, sel_A, sel_B, load_out}, e.fl);
            if (load_out) chk("alu_op", op, e.op);
            if ((en_A && !sel_A) || (en_B && !sel_B)) chk("imm_data", imm_data, e.imm);
          end
        end
      end else begin
        hold_chk = 1'b0;
      end
    end
  end

  task automatic push_ev(input logic [4:0] fl, input alu_op_e o, input logic [7:0] imm);
    ev_t e;
    e.fl = fl; e.op = o; e.imm = imm;
    exp_q.push_back(e);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_pc", pc, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_illegal", illegal, 1'b0);
    chk("rst_strobes", {en_A, en_B, sel_A, sel_B, load_out}, 5'b00000);
    chk("rst_op", op, ALU_ADD);
    chk("rst_imm", imm_data, 8'h00);
    exp_q.delete();
    fetch_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_halt(input int max_cyc);
    int k;
    k = 0;
    while (!halted && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    chk("halt_reached", halted, 1'b1);
  endtask

  task automatic chk_drained();
    chk("scoreboard_drained", exp_q.size(), 0);
  endtask

  task automatic chk_log(input string tag, input int idx, input logic [7:0] exp);
    logic [7:0] got;
    got = (idx < fetch_log.size()) ? fetch_log[idx] : 8'hxx;
    chk(tag, got, exp);
  endtask

  task automatic prog_ld_add();
    clr_mem();
    mem[0] = 8'h10; mem[1] = 8'h05; mem[2] = 8'h20;
    mem[3] = 8'h03; mem[4] = 8'h50; mem[5] = 8'hF0;
  endtask

  initial begin
    int k;
    // Load/load/add/halt, zero-wait memory
    delay = 0;
    prog_ld_add();
    do_reset();
    push_ev(5'b10000, ALU_ADD, 8'h05);
    push_ev(5'b01000, ALU_ADD, 8'h03);
    push_ev(5'b00001, ALU_ADD, 8'h00);
    wait_halt(100);
    chk("t1_out_reg", out_q, 8'h08);
    chk("t1_pc", pc, 8'h06);
    repeat (3) begin
      @(negedge clk);
      chk("t1_req_idle", imem_req, 1'b0);
      chk("t1_halted_hold", halted, 1'b1);
    end
    chk_drained();

    // Same program with three wait cycles per fetch
    delay = 3;
    prog_ld_add();
    do_reset();
    push_ev(5'b10000, ALU_ADD, 8'h05);
    push_ev(5'b01000, ALU_ADD, 8'h03);
    push_ev(5'b00001, ALU_ADD, 8'h00);
    wait_halt(300);
    chk("t2_out_reg", out_q, 8'h08);
    chk("t2_pc", pc, 8'h06);
    chk_drained();

    // SUB to zero then JZ taken, then not taken
    delay = 0;
    for (int pass = 0; pass < 2; pass++) begin
      clr_mem();
      mem[0] = 8'h10; mem[1] = (pass == 0) ? 8'h01 : 8'h02;
      mem[2] = 8'h20; mem[3] = 8'h01; mem[4] = 8'h60;
      mem[5] = 8'hA0; mem[6] = 8'h20; mem[7] = 8'hF0;
      do_reset();
      push_ev(5'b10000, ALU_ADD, (pass == 0) ? 8'h01 : 8'h02);
      push_ev(5'b01000, ALU_ADD, 8'h01);
      push_ev(5'b00001, ALU_SUB, 8'h00);
      wait_halt(100);
      chk("t3_out_reg", out_q, (pass == 0) ? 8'h00 : 8'h01);
      chk("t3_pc", pc, (pass == 0) ? 8'h21 : 8'h08);
      chk_drained();
    end

    // Undefined opcode then halt
    clr_mem();
    mem[0] = 8'hC0; mem[1] = 8'hF0;
    do_reset();
    wait_halt(100);
    chk("t4_illegal", illegal, 1'b1);
    chk("t4_pc", pc, 8'h02);
    repeat (2) @(negedge clk);
    chk("t4_illegal_sticky", illegal, 1'b1);
    chk_drained();

    // JMP whose operand byte sits at FF
    clr_mem();
    mem[0] = 8'h90; mem[1] = 8'hFE; mem[8'hFE] = 8'h90; mem[8'hFF] = 8'h10;
    do_reset();
    wait_halt(100);
    chk("t5_pc", pc, 8'h11);
    chk_log("t5_log0", 0, 8'h00);
    chk_log("t5_log2", 2, 8'hFE);
    chk_log("t5_log3", 3, 8'hFF);
    chk_log("t5_log4", 4, 8'h10);

    // NOP at FF wraps the program counter to 00
    clr_mem();
    mem[0] = 8'h90; mem[1] = 8'hFF; mem[8'hFF] = 8'h00;
    do_reset();
    repeat (20) @(negedge clk);
    chk_log("t5b_log2", 2, 8'hFF);
    chk_log("t5b_log3", 3, 8'h00);
    chk_log("t5b_log4", 4, 8'h01);
    chk("t5b_not_halted", halted, 1'b0);

    // Reset while waiting on the operand fetch
    delay = 5;
    prog_ld_add();
    mem[2] = 8'hF0;
    do_reset();
    k = 0;
    while (!(imem_req && imem_addr == 8'h01) && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_reached_opnd", {imem_req, imem_addr}, {1'b1, 8'h01});
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("t6_req_async", imem_req, 1'b0);
    chk("t6_pc_async", pc, 8'h00);
    do_reset();
    push_ev(5'b10000, ALU_ADD, 8'h05);
    wait_halt(300);
    chk("t6_a_reg", a_q, 8'h05);
    chk("t6_pc", pc, 8'h03);
    chk_log("t6_restart", 0, 8'h00);
    chk_drained();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
